// File: rtl/s2b_pkg.sv
// Shared definitions for the s2b frame parser: sync default, status codes and FSM states.
package s2b_pkg;

  localparam logic [15:0] SYNC_DEFAULT = 16'hA55A;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } s2b_err_e;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } s2b_state_e;

endpackage

// File: rtl/s2b_sat_cnt.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module s2b_sat_cnt #(
  parameter int W = 16
) (
  input  logic         dout_clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge dout_clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/s2b_frame_parser.sv
// Frame parser for the 16-bit CDC word stream: sync hunt, length header, cut-through payload,
// additive checksum check, per-frame status pulse and saturating ok/error frame counters.
module s2b_frame_parser
  import s2b_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_DEFAULT,
  parameter int          MAX_LEN   = 64,
  parameter int          TIMEOUT   = 32,
  parameter int          CNT_W     = 16
) (
  input  logic             dout_clk,
  input  logic             rstn,
  input  logic [15:0]      din_word,
  input  logic             din_vld,
  output logic [15:0]      frm_data,
  output logic             frm_vld,
  output logic             frm_sof,
  output logic             frm_eof,
  output logic             frm_done,
  output logic             frm_ok,
  output logic [1:0]       frm_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam int REM_W  = $clog2(MAX_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  // Flow control: din_vld qualifies din_word for exactly one cycle and there is no ready;
  // every qualified word is consumed the cycle it arrives. frm_vld likewise has no ready.

  s2b_state_e        state, state_nxt;
  logic [REM_W-1:0]  rem, rem_nxt;
  logic [IDLE_W-1:0] idle, idle_nxt;
  logic [15:0]       sum, sum_nxt;
  logic              first, first_nxt;

  logic [15:0] data_nxt;
  logic        vld_nxt, sof_nxt, eof_nxt, done_nxt, ok_nxt;
  logic [1:0]  err_nxt;
  logic        idle_expire;

  // A word in the would-expire cycle is processed instead of timing out, since din_vld gates this.
  assign idle_expire = (state != ST_HUNT) && !din_vld && (idle == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge dout_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_HUNT;
      rem      <= '0;
      idle     <= '0;
      sum      <= '0;
      first    <= 1'b0;
      frm_data <= '0;
      frm_vld  <= 1'b0;
      frm_sof  <= 1'b0;
      frm_eof  <= 1'b0;
      frm_done <= 1'b0;
      frm_ok   <= 1'b0;
      frm_err  <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      idle     <= idle_nxt;
      sum      <= sum_nxt;
      first    <= first_nxt;
      frm_data <= data_nxt;
      frm_vld  <= vld_nxt;
      frm_sof  <= sof_nxt;
      frm_eof  <= eof_nxt;
      frm_done <= done_nxt;
      frm_ok   <= ok_nxt;
      frm_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    sum_nxt   = sum;
    first_nxt = first;
    data_nxt  = '0;
    vld_nxt   = 1'b0;
    sof_nxt   = 1'b0;
    eof_nxt   = 1'b0;
    done_nxt  = 1'b0;
    ok_nxt    = 1'b0;
    err_nxt   = ERR_NONE;

    if (din_vld || (state == ST_HUNT)) begin
      idle_nxt = '0;
    end else begin
      idle_nxt = idle + IDLE_W'(1);
    end

    case (state)
      ST_HUNT: begin
        if (din_vld && (din_word == SYNC_WORD)) begin
          state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (din_vld) begin
          if ((din_word == 16'd0) || (din_word > 16'(MAX_LEN))) begin
            done_nxt  = 1'b1;
            err_nxt   = ERR_LEN;
            state_nxt = ST_HUNT;
          end else begin
            rem_nxt   = din_word[REM_W-1:0];
            sum_nxt   = din_word;
            first_nxt = 1'b1;
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (din_vld) begin
          vld_nxt   = 1'b1;
          data_nxt  = din_word;
          sof_nxt   = first;
          eof_nxt   = (rem == REM_W'(1));
          first_nxt = 1'b0;
          sum_nxt   = sum + din_word;
          rem_nxt   = rem - REM_W'(1);
          if (rem == REM_W'(1)) begin
            state_nxt = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (din_vld) begin
          done_nxt  = 1'b1;
          state_nxt = ST_HUNT;
          if (din_word == sum) begin
            ok_nxt = 1'b1;
          end else begin
            err_nxt = ERR_CSUM;
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase

    if (idle_expire) begin
      done_nxt  = 1'b1;
      ok_nxt    = 1'b0;
      err_nxt   = ERR_TIMEOUT;
      state_nxt = ST_HUNT;
      idle_nxt  = '0;
    end
  end

  s2b_sat_cnt #(.W(CNT_W)) u_cnt_ok (
    .dout_clk (dout_clk),
    .rstn     (rstn),
    .inc      (done_nxt & ok_nxt),
    .cnt      (cnt_ok)
  );

  s2b_sat_cnt #(.W(CNT_W)) u_cnt_err (
    .dout_clk (dout_clk),
    .rstn     (rstn),
    .inc      (done_nxt & ~ok_nxt),
    .cnt      (cnt_err)
  );

endmodule

// File: tb/tb_s2b_frame_parser.sv
// Directed bench for s2b_frame_parser: vector table plus hand sequences for timeout,
// counter saturation (second instance with 2-bit counters) and reset mid-frame.
module tb_s2b_frame_parser;

  logic        dout_clk;
  logic        rstn;
  logic [15:0] din_word;
  logic        din_vld;

  logic [15:0] frm_data;
  logic        frm_vld, frm_sof, frm_eof, frm_done, frm_ok;
  logic [1:0]  frm_err;
  logic [15:0] cnt_ok, cnt_err;

  logic [15:0] s_frm_data;
  logic        s_frm_vld, s_frm_sof, s_frm_eof, s_frm_done, s_frm_ok;
  logic [1:0]  s_frm_err;
  logic [1:0]  s_cnt_ok, s_cnt_err;

  int n_checks = 0;
  int n_errors = 0;

  // {vld, sof, eof, done, ok, err[1:0], data[15:0]}
  typedef struct {
    logic        vld;
    logic [15:0] word;
    logic [22:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [22:0] exp_q[$];

  s2b_frame_parser #(.CNT_W(16)) dut (
    .dout_clk (dout_clk), .rstn (rstn), .din_word (din_word), .din_vld (din_vld),
    .frm_data (frm_data), .frm_vld (frm_vld), .frm_sof (frm_sof), .frm_eof (frm_eof),
    .frm_done (frm_done), .frm_ok (frm_ok), .frm_err (frm_err),
    .cnt_ok (cnt_ok), .cnt_err (cnt_err)
  );

  s2b_frame_parser #(.CNT_W(2)) dut_s (
    .dout_clk (dout_clk), .rstn (rstn), .din_word (din_word), .din_vld (din_vld),
    .frm_data (s_frm_data), .frm_vld (s_frm_vld), .frm_sof (s_frm_sof), .frm_eof (s_frm_eof),
    .frm_done (s_frm_done), .frm_ok (s_frm_ok), .frm_err (s_frm_err),
    .cnt_ok (s_cnt_ok), .cnt_err (s_cnt_err)
  );

  // clock / reset
  initial dout_clk = 1'b0;
  always #5 dout_clk = ~dout_clk;

  function automatic logic [22:0] mk(input logic v, input logic sof, input logic eof,
                                     input logic done, input logic ok, input logic [1:0] err,
                                     input logic [15:0] data);
    return {v, sof, eof, done, ok, err, data};
  endfunction

  function automatic logic [22:0] got_vec();
    return {frm_vld, frm_sof, frm_eof, frm_done, frm_ok, frm_err, frm_data};
  endfunction

  function automatic logic s_any_out();
    return s_frm_vld | s_frm_sof | s_frm_eof | s_frm_done | s_frm_ok | (|s_frm_err) | (|s_frm_data);
  endfunction

  task automatic add(input logic v, input logic [15:0] w, input logic [22:0] e);
    vec_t r;
    r.vld = v; r.word = w; r.exp = e;
    tbl.push_back(r);
  endtask

  // driver: present one cycle of input, then sample 1 time unit after the accepting edge
  task automatic step(input logic v, input logic [15:0] w);
    @(negedge dout_clk);
    din_vld  = v;
    din_word = w;
    @(posedge dout_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step_chk(input string name, input logic v, input logic [15:0] w,
                          input logic [22:0] e);
    step(v, w);
    exp_q.push_back(e);
    check(name, 32'(got_vec()), 32'(exp_q.pop_front()));
  endtask

  task automatic do_reset();
    @(negedge dout_clk);
    rstn = 1'b0; din_vld = 1'b0; din_word = '0;
    repeat (2) @(negedge dout_clk);
    rstn = 1'b1;
  endtask

  localparam logic [22:0] Z = 23'd0;

  initial begin
    logic [22:0] t_done;
    logic        seen;

    rstn = 1'b0; din_vld = 1'b0; din_word = '0;
    repeat (2) @(posedge dout_clk);
    #1;
    check("reset_outputs", 32'(got_vec()), 32'(Z));
    check("reset_cnt_ok", 32'(cnt_ok), 32'd0);
    check("reset_cnt_err", 32'(cnt_err), 32'd0);
    @(negedge dout_clk);
    rstn = 1'b1;

    // good frame
    add(1, 16'hA55A, Z);
    add(1, 16'h0003, Z);
    add(1, 16'h0001, mk(1, 1, 0, 0, 0, 2'd0, 16'h0001));
    add(0, 16'h0000, Z);
    add(1, 16'h0002, mk(1, 0, 0, 0, 0, 2'd0, 16'h0002));
    add(1, 16'h0003, mk(1, 0, 1, 0, 0, 2'd0, 16'h0003));
    add(1, 16'h0009, mk(0, 0, 0, 1, 1, 2'd0, 16'h0000));
    // bad checksum: 2+1111+2222 = 3335
    add(1, 16'hA55A, Z);
    add(1, 16'h0002, Z);
    add(1, 16'h1111, mk(1, 1, 0, 0, 0, 2'd0, 16'h1111));
    add(1, 16'h2222, mk(1, 0, 1, 0, 0, 2'd0, 16'h2222));
    add(1, 16'h0000, mk(0, 0, 0, 1, 0, 2'd2, 16'h0000));
    // bad lengths 0 and 65
    add(1, 16'hA55A, Z);
    add(1, 16'h0000, mk(0, 0, 0, 1, 0, 2'd1, 16'h0000));
    add(1, 16'hA55A, Z);
    add(1, 16'h0041, mk(0, 0, 0, 1, 0, 2'd1, 16'h0000));
    // junk then two back-to-back frames carrying the sync value as data
    add(1, 16'h1234, Z);
    add(1, 16'hA55B, Z);
    add(1, 16'hA55A, Z);
    add(1, 16'h0002, Z);
    add(1, 16'hA55A, mk(1, 1, 0, 0, 0, 2'd0, 16'hA55A));
    add(1, 16'h0005, mk(1, 0, 1, 0, 0, 2'd0, 16'h0005));
    add(1, 16'hA561, mk(0, 0, 0, 1, 1, 2'd0, 16'h0000));
    add(1, 16'hA55A, Z);
    add(1, 16'h0001, Z);
    add(1, 16'hA55A, mk(1, 1, 1, 0, 0, 2'd0, 16'hA55A));
    add(1, 16'hA55B, mk(0, 0, 0, 1, 1, 2'd0, 16'h0000));

    for (int i = 0; i < tbl.size(); i++) begin
      step_chk($sformatf("vec%0d", i), tbl[i].vld, tbl[i].word, tbl[i].exp);
    end
    check("tbl_cnt_ok", 32'(cnt_ok), 32'd3);
    check("tbl_cnt_err", 32'(cnt_err), 32'd3);

    // timeout after exactly 32 idle cycles
    t_done = mk(0, 0, 0, 1, 0, 2'd3, 16'h0000);
    step_chk("to_sync", 1, 16'hA55A, Z);
    step_chk("to_len", 1, 16'h0004, Z);
    step_chk("to_pay", 1, 16'h0001, mk(1, 1, 0, 0, 0, 2'd0, 16'h0001));
    seen = 1'b0;
    for (int i = 0; i < 31; i++) begin
      step(0, 16'h0000);
      if (got_vec() !== Z) seen = 1'b1;
    end
    check("to_early", 32'(seen), 32'd0);
    step_chk("to_fire", 0, 16'h0000, t_done);
    check("to_cnt_err", 32'(cnt_err), 32'd4);
    step_chk("rec_sync", 1, 16'hA55A, Z);
    step_chk("rec_len", 1, 16'h0001, Z);
    step_chk("rec_pay", 1, 16'hBEEF, mk(1, 1, 1, 0, 0, 2'd0, 16'hBEEF));
    step_chk("rec_csum", 1, 16'hBEF0, mk(0, 0, 0, 1, 1, 2'd0, 16'h0000));

    // word on the would-expire cycle wins
    step_chk("win_sync", 1, 16'hA55A, Z);
    step_chk("win_len", 1, 16'h0002, Z);
    step_chk("win_p0", 1, 16'h0001, mk(1, 1, 0, 0, 0, 2'd0, 16'h0001));
    seen = 1'b0;
    for (int i = 0; i < 31; i++) begin
      step(0, 16'h0000);
      if (got_vec() !== Z) seen = 1'b1;
    end
    check("win_idle", 32'(seen), 32'd0);
    step_chk("win_p1", 1, 16'h0002, mk(1, 0, 1, 0, 0, 2'd0, 16'h0002));
    step_chk("win_csum", 1, 16'h0005, mk(0, 0, 0, 1, 1, 2'd0, 16'h0000));
    check("win_cnt_ok", 32'(cnt_ok), 32'd5);

    // saturation on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_chk($sformatf("sat_sync%0d", i), 1, 16'hA55A, Z);
      step_chk($sformatf("sat_len%0d", i), 1, 16'h0000, mk(0, 0, 0, 1, 0, 2'd1, 16'h0000));
    end
    check("sat_s_cnt_err", 32'(s_cnt_err), 32'd3);
    check("sat_s_cnt_ok", 32'(s_cnt_ok), 32'd0);
    check("sat_cnt_err", 32'(cnt_err), 32'd5);

    // reset mid-payload
    step_chk("rst_sync", 1, 16'hA55A, Z);
    step_chk("rst_len", 1, 16'h0003, Z);
    step_chk("rst_pay", 1, 16'h0001, mk(1, 1, 0, 0, 0, 2'd0, 16'h0001));
    @(negedge dout_clk);
    rstn = 1'b0; din_vld = 1'b0;
    #1;
    check("rst_outputs", 32'(got_vec()), 32'(Z));
    check("rst_cnt_err", 32'(cnt_err), 32'd0);
    check("rst_s_outputs", 32'(s_any_out()), 32'd0);
    @(negedge dout_clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(0, 16'h0000);
      if (got_vec() !== Z) seen = 1'b1;
    end
    check("rst_no_status", 32'(seen), 32'd0);
    step_chk("rst_hunt_drop", 1, 16'h0002, Z);
    step_chk("post_sync", 1, 16'hA55A, Z);
    step_chk("post_len", 1, 16'h0001, Z);
    step_chk("post_pay", 1, 16'h0007, mk(1, 1, 1, 0, 0, 2'd0, 16'h0007));
    step_chk("post_csum", 1, 16'h0008, mk(0, 0, 0, 1, 1, 2'd0, 16'h0000));
    check("post_cnt_ok", 32'(cnt_ok), 32'd1);
    check("post_cnt_err", 32'(cnt_err), 32'd0);
    step(0, 16'h0000);

    // report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
